// File: rtl/region_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : region_loader_pkg
// Description : Shared constants for region boundary loading: frame header,
//               region ids, FSM state encoding and a region one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package region_loader_pkg;

    localparam int         c_n_points_default = 812;
    localparam int         c_timeout_default  = 50000;
    localparam logic [7:0] c_header           = 8'hA5;

    localparam logic [1:0] c_region_inner  = 2'd0;
    localparam logic [1:0] c_region_middle = 2'd1;
    localparam logic [1:0] c_region_outer  = 2'd2;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_id      = 3'd1;
    localparam logic [2:0] c_st_data_hi = 3'd2;
    localparam logic [2:0] c_st_data_lo = 3'd3;
    localparam logic [2:0] c_st_csum    = 3'd4;

    // Region id to RAM select; ids outside 0..2 select nothing.
    function automatic logic [2:0] region_onehot(input logic [1:0] id);
        logic [2:0] v_sel;
        case (id)
            c_region_inner:  v_sel = 3'b001;
            c_region_middle: v_sel = 3'b010;
            c_region_outer:  v_sel = 3'b100;
            default:         v_sel = 3'b000;
        endcase
        return v_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/region_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : region_loader_if
// Description : Configuration byte stream in, region RAM write port and
//               load status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface region_loader_if;

    logic        cfg_valid;
    logic [7:0]  cfg_data;
    logic [2:0]  region_wren;
    logic [9:0]  region_wraddr;
    logic [17:0] region_wrdata;
    logic [2:0]  region_valid;
    logic        busy;
    logic        load_done;
    logic        load_err;

    modport master (
        output cfg_valid, cfg_data,
        input  region_wren, region_wraddr, region_wrdata, region_valid,
        input  busy, load_done, load_err
    );

    modport slave (
        input  cfg_valid, cfg_data,
        output region_wren, region_wraddr, region_wrdata, region_valid,
        output busy, load_done, load_err
    );

endinterface
`default_nettype wire

// File: rtl/region_loader.sv
`default_nettype none
// ============================================================================
// Module      : region_loader
// Description : Parses framed boundary-point uploads and writes them into one
//               of three region RAMs, validating each frame by XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module region_loader
    import region_loader_pkg::*;
#(
    parameter int         N_POINTS = c_n_points_default,
    parameter logic [7:0] HEADER   = c_header,
    parameter int         TIMEOUT  = c_timeout_default
) (
    input  wire logic       clk,
    input  wire logic       rst,
    region_loader_if.slave  bus
);

    localparam int                 c_gap_w    = $clog2(TIMEOUT + 1);
    localparam logic [9:0]         c_last_pt  = 10'(N_POINTS - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [1:0]         r_id;
    logic [9:0]         r_cnt;
    logic [7:0]         r_hi;
    logic [7:0]         r_csum;
    logic [c_gap_w-1:0] r_gap;
    logic [2:0]         r_wren;
    logic [9:0]         r_wraddr;
    logic [17:0]        r_wrdata;
    logic [2:0]         r_valid;
    logic               r_done;
    logic               r_err;

    logic               w_timeout;

    // An accepted byte always beats an expiring gap counter.
    assign w_timeout = (r_state != c_st_idle) && !bus.cfg_valid && (r_gap == c_gap_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_id     <= 2'd0;
            r_cnt    <= 10'd0;
            r_hi     <= 8'd0;
            r_csum   <= 8'd0;
            r_gap    <= '0;
            r_wren   <= 3'b000;
            r_wraddr <= 10'd0;
            r_wrdata <= 18'd0;
            r_valid  <= 3'b000;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wren <= 3'b000;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (bus.cfg_valid) begin
                r_gap <= '0;
                case (r_state)
                    c_st_idle: begin
                        if (bus.cfg_data == HEADER) begin
                            r_state <= c_st_id;
                        end
                    end
                    c_st_id: begin
                        if (bus.cfg_data <= 8'd2) begin
                            r_id    <= bus.cfg_data[1:0];
                            r_valid <= r_valid & ~region_onehot(bus.cfg_data[1:0]);
                            r_cnt   <= 10'd0;
                            r_csum  <= bus.cfg_data;
                            r_state <= c_st_data_hi;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_st_idle;
                        end
                    end
                    c_st_data_hi: begin
                        r_hi    <= bus.cfg_data;
                        r_csum  <= r_csum ^ bus.cfg_data;
                        r_state <= c_st_data_lo;
                    end
                    c_st_data_lo: begin
                        r_csum   <= r_csum ^ bus.cfg_data;
                        r_wren   <= region_onehot(r_id);
                        r_wraddr <= r_cnt;
                        r_wrdata <= {2'b00, r_hi, bus.cfg_data};
                        if (r_cnt == c_last_pt) begin
                            r_state <= c_st_csum;
                        end else begin
                            r_cnt   <= r_cnt + 10'd1;
                            r_state <= c_st_data_hi;
                        end
                    end
                    c_st_csum: begin
                        if (bus.cfg_data == r_csum) begin
                            r_valid <= r_valid | region_onehot(r_id);
                            r_done  <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                        end
                        r_state <= c_st_idle;
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end else if (r_state != c_st_idle) begin
                if (w_timeout) begin
                    r_state <= c_st_idle;
                    r_err   <= 1'b1;
                    r_gap   <= '0;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
            end
        end
    end

    assign bus.region_wren   = r_wren;
    assign bus.region_wraddr = r_wraddr;
    assign bus.region_wrdata = r_wrdata;
    assign bus.region_valid  = r_valid;
    assign bus.busy          = (r_state != c_st_idle);
    assign bus.load_done     = r_done;
    assign bus.load_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_region_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_region_loader
// Description : Directed frame uploads checked cycle by cycle against a
//               byte-position model of the frame format, plus literal totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_region_loader;

    localparam int         c_np  = 812;
    localparam int         c_to  = 2000;
    localparam logic [7:0] c_hdr = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    region_loader_if bus ();

    region_loader #(
        .N_POINTS (c_np),
        .HEADER   (c_hdr),
        .TIMEOUT  (c_to)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: position within frame rather than parser states.
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    int         m_gap    = 0;
    logic [1:0] m_id     = 2'd0;
    logic [7:0] m_x      = 8'd0;
    logic [7:0] m_hi     = 8'd0;
    logic [2:0] m_valid  = 3'b000;
    logic [2:0] m_wren   = 3'b000;
    logic [9:0] m_addr   = 10'd0;
    logic [17:0] m_data  = 18'd0;
    bit         m_done   = 1'b0;
    bit         m_err    = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        m_wren = 3'b000;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_gap    = 0;
            m_valid  = 3'b000;
            m_x      = 8'd0;
        end else if (bus.cfg_valid) begin
            m_gap = 0;
            if (!m_active) begin
                if (bus.cfg_data == c_hdr) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end else if (m_pos == 0) begin
                if (bus.cfg_data > 8'd2) begin
                    m_err    = 1'b1;
                    m_active = 1'b0;
                end else begin
                    m_id          = bus.cfg_data[1:0];
                    m_valid[m_id] = 1'b0;
                    m_x           = bus.cfg_data;
                    m_pos         = 1;
                end
            end else if (m_pos <= 2 * c_np) begin
                m_x = m_x ^ bus.cfg_data;
                if (m_pos % 2 == 1) begin
                    m_hi = bus.cfg_data;
                end else begin
                    m_wren = 3'(3'b001 << m_id);
                    m_addr = 10'((m_pos / 2) - 1);
                    m_data = {2'b00, m_hi, bus.cfg_data};
                end
                m_pos++;
            end else begin
                if (bus.cfg_data == m_x) begin
                    m_done        = 1'b1;
                    m_valid[m_id] = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_active = 1'b0;
            end
        end else if (m_active) begin
            m_gap++;
            if (m_gap >= c_to) begin
                m_err    = 1'b1;
                m_active = 1'b0;
                m_gap    = 0;
            end
        end
    end

    int          wr_cnt    = 0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    logic [17:0] last_wr   = 18'd0;
    logic [2:0]  last_wren = 3'b000;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("wren", 32'(bus.region_wren), 32'(m_wren));
            if (m_wren != 3'b000) begin
                chk("wraddr", 32'(bus.region_wraddr), 32'(m_addr));
                chk("wrdata", 32'(bus.region_wrdata), 32'(m_data));
            end
            chk("region_valid", 32'(bus.region_valid), 32'(m_valid));
            chk("busy", 32'(bus.busy), 32'(m_active));
            chk("load_done", 32'(bus.load_done), 32'(m_done));
            chk("load_err", 32'(bus.load_err), 32'(m_err));
            chk("done_err_excl", 32'(bus.load_done & bus.load_err), 32'd0);
        end
        if (bus.region_wren != 3'b000) begin
            wr_cnt++;
            last_wr   = bus.region_wrdata;
            last_wren = bus.region_wren;
        end
        if (bus.load_done) done_cnt++;
        if (bus.load_err)  err_cnt++;
    end

    task automatic clr_obs();
        @(posedge clk);
        #2;
        wr_cnt   = 0;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.cfg_valid = 1'b0;
            bus.cfg_data  = 8'h00;
        end
    endtask

    function automatic logic [15:0] pt(input int kind, input int k);
        logic [15:0] v;
        if (kind == 0) begin
            v = 16'(16'h0100 + k);
        end else begin
            case (k % 4)
                0:       v = 16'hFFFF;
                1:       v = 16'hA5A5;
                2:       v = {8'hA5, 8'(k)};
                default: v = {8'(k), 8'hA5};
            endcase
        end
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wren"},   32'(bus.region_wren),   32'd0);
        chk({tag, "_wraddr"}, 32'(bus.region_wraddr), 32'd0);
        chk({tag, "_wrdata"}, 32'(bus.region_wrdata), 32'd0);
        chk({tag, "_valid"},  32'(bus.region_valid),  32'd0);
        chk({tag, "_busy"},   32'(bus.busy),          32'd0);
        chk({tag, "_done"},   32'(bus.load_done),     32'd0);
        chk({tag, "_err"},    32'(bus.load_err),      32'd0);
    endtask

    // stall_pt/rst_pt < 0 disables that event; a stall of c_to cycles aborts the frame.
    task automatic frame(input logic [7:0] id, input int kind, input logic [7:0] flip,
                         input int stall_pt, input int stall_len, input int rst_pt);
        logic [7:0]  x;
        logic [15:0] p;
        x = id;
        send(c_hdr);
        send(id);
        if (id > 8'd2) begin
            idle(4);
            return;
        end
        for (int k = 0; k < c_np; k++) begin
            p = pt(kind, k);
            send(p[15:8]);
            send(p[7:0]);
            x = x ^ p[15:8] ^ p[7:0];
            if (k == rst_pt) begin
                @(posedge clk);
                #2;
                rst = 1'b1;
                bus.cfg_valid = 1'b0;
                @(negedge clk);
                #1;
                check_reset_outputs("midreset");
                rst = 1'b0;
                idle(4);
                return;
            end
            if (k == stall_pt) begin
                idle(stall_len);
                if (stall_len >= c_to) begin
                    idle(4);
                    return;
                end
            end
        end
        send(x ^ flip);
        idle(4);
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // good frame, region 1
        clr_obs();
        frame(8'd1, 0, 8'h00, -1, 0, -1);
        clr_obs_check(812, 1, 0, 3'b010);
        chk("t1_last_wrdata", 32'(last_wr), 32'h0042B);
        chk("t1_last_wren", 32'(last_wren), 32'h2);

        // corrupted checksum
        clr_obs();
        frame(8'd1, 0, 8'h01, -1, 0, -1);
        clr_obs_check(812, 0, 1, 3'b000);

        // illegal id
        clr_obs();
        frame(8'd3, 0, 8'h00, -1, 0, -1);
        clr_obs_check(0, 0, 1, 3'b000);
        chk("t3_busy", 32'(bus.busy), 32'd0);

        // full-length stall aborts
        clr_obs();
        frame(8'd2, 0, 8'h00, 100, c_to, -1);
        clr_obs_check(101, 0, 1, 3'b000);
        chk("t4_busy", 32'(bus.busy), 32'd0);

        // stall one short of the limit survives
        clr_obs();
        frame(8'd2, 0, 8'h00, 100, c_to - 1, -1);
        clr_obs_check(812, 1, 0, 3'b100);

        // header bytes and no-boundary markers as data
        clr_obs();
        frame(8'd0, 1, 8'h00, -1, 0, -1);
        clr_obs_check(812, 1, 0, 3'b101);
        chk("t6_last_wrdata", 32'(last_wr), 32'h02BA5);

        // reset in mid-frame, then reload region 0
        clr_obs();
        frame(8'd1, 0, 8'h00, -1, 0, 400);
        clr_obs_check(400, 0, 0, 3'b000);
        clr_obs();
        frame(8'd0, 0, 8'h00, -1, 0, -1);
        clr_obs_check(812, 1, 0, 3'b001);
        chk("t8_last_wrdata", 32'(last_wr), 32'h0042B);
        chk("t8_last_wren", 32'(last_wren), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    task automatic clr_obs_check(input int exp_wr, input int exp_done, input int exp_err,
                                 input logic [2:0] exp_valid);
        @(posedge clk);
        #2;
        chk("write_count", 32'(wr_cnt), 32'(exp_wr));
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        chk("err_count", 32'(err_cnt), 32'(exp_err));
        chk("final_valid", 32'(bus.region_valid), 32'(exp_valid));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/region_loader.md
REGION_LOADER -- requirements
Module: region_loader

Interface
REQ-001 Parameter N_POINTS, default 812, number of boundary points per region (RAM addresses 0..N_POINTS-1).
REQ-002 Parameter HEADER, default 8'hA5, frame start byte.
REQ-003 Parameter TIMEOUT, default 50000, maximum idle cycles between bytes inside a frame.
REQ-004 Port clk, input, 1, single clock for all logic.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port cfg_valid, input, 1, cfg_data is valid this cycle (one byte accepted per asserted cycle, no backpressure).
REQ-007 Port cfg_data, input, 8, configuration byte stream from host interface.
REQ-008 Port region_wren, output, 3, one-hot write enable for region RAM 0 (inner), 1 (middle), 2 (outer).
REQ-009 Port region_wraddr, output, 10, RAM write address.
REQ-010 Port region_wrdata, output, 18, RAM write data, {2'b00, point[15:0]}.
REQ-011 Port region_valid, output, 3, per-region flag: last frame for that region completed with good checksum.
REQ-012 Port busy, output, 1, high while a frame is in progress (any state other than IDLE).
REQ-013 Port load_done, output, 1, one-cycle pulse on good frame completion.
REQ-014 Port load_err, output, 1, one-cycle pulse on frame abort (bad id, bad checksum, timeout).

Function
REQ-015 Frame format SHALL be: HEADER, region id (0..2), N_POINTS x {high byte, low byte}, checksum byte.
REQ-016 FSM states SHALL be IDLE, ID, DATA_HI, DATA_LO, CSUM; transitions occur only on cfg_valid except timeout.
REQ-017 IDLE -> ID on byte == HEADER; other bytes in IDLE are discarded.
REQ-018 ID: id <= 2 -> DATA_HI, clears region_valid[id] same cycle, zeroes point counter and checksum; id > 2 -> IDLE with load_err, no writes.
REQ-019 DATA_HI stores high byte -> DATA_LO; DATA_LO -> DATA_HI, or -> CSUM when the completed point index == N_POINTS-1.
REQ-020 Write of a point SHALL occur one cycle after its low byte is accepted: region_wren[id]=1 for exactly one cycle, wraddr = point index, wrdata = {2'b00, hi, lo}.
REQ-021 Point values are written unmodified, including 16'hFFFF (no-boundary marker).
REQ-022 Byte value HEADER inside a frame SHALL be treated as data, not resynchronisation.
REQ-023 Checksum = XOR of id byte and all 2*N_POINTS data bytes; CSUM byte match -> region_valid[id]=1 and load_done pulse; mismatch -> load_err, region_valid[id] stays 0; both return to IDLE.
REQ-024 Gap counter counts cycles without cfg_valid while not IDLE; reaching TIMEOUT -> IDLE, load_err; cfg_valid in the same cycle wins (byte accepted, counter cleared).
REQ-025 Points already written in an aborted frame remain in RAM; region_valid[id] = 0 marks them untrusted.
REQ-026 region_wren SHALL be 3'b000 in every cycle except REQ-020 write cycles; never more than one bit set.
REQ-027 load_done and load_err SHALL never assert together.

Reset
REQ-028 On rst: state IDLE, region_wren 0, region_wraddr 0, region_wrdata 0, region_valid 3'b000, busy 0, load_done 0, load_err 0, counters and checksum 0.
REQ-029 Reset asserted mid-frame SHALL abort immediately with no further writes and no load_err pulse.

Structure
REQ-030 Shared package SHALL hold N_POINTS default, HEADER, region id constants (0,1,2) and FSM state encoding, shared with the region comparator.
REQ-031 Single module, no sub-modules; the gap counter is inline.

Verification
REQ-032 Good frame id=1, points k -> 16'h0100+k, correct checksum -> 812 writes on wren=3'b010, addr 0..811, last wrdata 18'h0042B, load_done once, region_valid=3'b010.
REQ-033 Same frame with checksum byte XOR 8'h01 -> load_err once, region_valid[1]=0, 812 writes still seen.
REQ-034 Frame id=3 -> load_err after the id byte, zero writes, busy low next cycle.
REQ-035 Stall 50000 cycles after point 100 -> load_err, IDLE; stall 49999 then resume -> frame completes with load_done.
REQ-036 Frame containing 8'hA5 and 16'hFFFF points -> written verbatim, frame completes normally.
REQ-037 Assert rst at point 400 -> outputs at reset values, no load_err; subsequent good frame id=0 loads correctly, region_valid=3'b001.
